// File: rtl/req_dec_pkg.sv
// Shared types and defaults for the request source decoder.
// Optional feature macro used by the decoder: ROUND_ROBIN_EN.
package req_dec_pkg;

   // Default number of request sources on the wired-OR line.
   localparam int REQ_DEC_N_DEFAULT = 4;

   // Handshake FSM state. It is kept as a plain vector with named constants
   // so that it matches the older blocks that compare state encodings directly.
   typedef logic [0:0] state_t;

   localparam state_t IDLE  = 1'b0;
   localparam state_t OFFER = 1'b1;

endpackage : req_dec_pkg

// File: rtl/req_pick.sv
// Combinational picker: finds the first set bit of a pending vector,
// searching upward from a start position and wrapping from N-1 back to 0.
// A start of zero gives plain lowest-index-wins priority.
module req_pick #(
   parameter  int N    = 4,
   localparam int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    pending,
   input  logic [IDXW-1:0] start,
   output logic            found,
   output logic [IDXW-1:0] idx
);

   logic [N-1:0] upper_mask;
   logic [N-1:0] masked;

   // Index of the lowest set bit, or zero when nothing is set.
   function automatic logic [IDXW-1:0] lowest_set(input logic [N-1:0] v);
      logic [IDXW-1:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = IDXW'(i);
         end
      end
      return r;
   endfunction

   // Keep only the bits at or above the start position; if none of those
   // are pending, the search wraps and takes the lowest pending bit overall.
   always_comb begin
      // NOTE: every output of a combinational block gets a default at the top,
      // so no path leaves it unassigned and no latch is inferred.
      upper_mask = '0;
      for (int i = 0; i < N; i++) begin
         upper_mask[i] = (IDXW'(i) >= start);
      end
      masked = pending & upper_mask;
      found  = |pending;
      idx    = (|masked) ? lowest_set(masked) : lowest_set(pending);
   end

endmodule : req_pick

// File: rtl/req_source_decoder.sv
// Request source decoder: recovers which of N sources raised the wired-OR
// request line. Rising edges are captured per source into a pending register,
// and source indices are handed one at a time to a consumer over valid/ready.
// Define ROUND_ROBIN_EN for a rotating pick; otherwise the lowest index wins.
module req_source_decoder
   import req_dec_pkg::*;
#(
   parameter  int N    = REQ_DEC_N_DEFAULT,
   localparam int IDXW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   output logic            any_pending,
   output logic            out_valid,
   output logic [IDXW-1:0] out_idx,
   input  logic            out_ready,
   output logic            ovf
);

   logic [N-1:0]    req_q;
   logic [N-1:0]    pending;
   logic [N-1:0]    rise;
   logic [N-1:0]    clr;
   state_t          state;
   logic            xfer;
   logic [IDXW-1:0] pick_start;
   logic            pick_found;
   logic [IDXW-1:0] pick_idx;

   // The offer is a direct decode of the FSM state; a transfer is the cycle
   // in which the consumer accepts it. Ready while idle is ignored.
   assign out_valid   = (state == OFFER);
   assign xfer        = out_valid & out_ready;
   assign rise        = req & ~req_q;
   assign any_pending = |pending;

   // One-hot clear mask for the bit being handed over this cycle.
   always_comb begin
      clr = '0;
      if (xfer) begin
         clr[out_idx] = 1'b1;
      end
   end

   // Edge capture and pending bookkeeping. A new edge on a bit that is being
   // cleared in the same cycle keeps it pending (set wins) and is not an
   // overflow; a new edge on a bit still pending raises the sticky ovf.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= '0;
         pending <= '0;
         ovf     <= 1'b0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // here samples the pre-edge values, independent of statement order.
         req_q   <= req;
         pending <= (pending & ~clr) | rise;
         if (|(rise & pending & ~clr)) begin
            ovf <= 1'b1;
         end
      end
   end

   // Handshake FSM: latch the picked index on entry to OFFER and hold it
   // until accepted, then spend one idle cycle before the next pick.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         out_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  out_idx <= pick_idx;
                  state   <= OFFER;
               end
            end
            OFFER: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ROUND_ROBIN_EN
   logic [IDXW-1:0] rr_ptr;

   // Rotate the search start to just past the index that was consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (out_idx == IDXW'(N - 1)) ? '0 : out_idx + 1'b1;
      end
   end

   assign pick_start = rr_ptr;
`else
   assign pick_start = '0;
`endif

   req_pick #(
      .N (N)
   ) u_pick (
      .pending (pending),
      .start   (pick_start),
      .found   (pick_found),
      .idx     (pick_idx)
   );

endmodule : req_source_decoder

// File: tb/tb_req_source_decoder.sv
// Scoreboard bench for req_source_decoder (N=4). Stimulus pushes the index
// it expects to be handed over; a monitor pops and compares on each transfer.
// Works with or without ROUND_ROBIN_EN defined.
module tb_req_source_decoder;

   localparam int N    = 4;
   localparam int IDXW = $clog2(N);

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic            any_pending;
   logic            out_valid;
   logic [IDXW-1:0] out_idx;
   logic            out_ready;
   logic            ovf;

   int total;
   int bad;
   int xfer_count;
   int exp_q[$];

   req_source_decoder #(
      .N (N)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .any_pending (any_pending),
      .out_valid   (out_valid),
      .out_idx     (out_idx),
      .out_ready   (out_ready),
      .ovf         (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance one clock; inputs change and direct checks happen 1 unit after the edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: inputs are stable at the falling edge, so valid & ready here is
   // exactly the transfer the next rising edge will perform.
   initial begin
      logic            hold;
      logic [IDXW-1:0] held_idx;
      int              exp_idx;
      hold     = 1'b0;
      held_idx = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
         end else begin
            if (out_valid && hold) begin
               check("idx_stable", 32'(out_idx), 32'(held_idx));
            end
            if (out_valid && out_ready) begin
               xfer_count++;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL xfer_unexpected: got idx %0d expected no transfer at %0t", out_idx, $time);
               end else begin
                  exp_idx = exp_q.pop_front();
                  check("xfer_idx", 32'(out_idx), 32'(exp_idx));
               end
            end
            hold     = out_valid && !out_ready;
            held_idx = out_idx;
         end
      end
   end

   initial begin
      total      = 0;
      bad        = 0;
      xfer_count = 0;

      // Reset held with all requests high, released with requests low.
      rst       = 1'b1;
      req       = 4'b1111;
      out_ready = 1'b0;
      tick(3);
      rst = 1'b0;
      req = 4'b0000;
      tick();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_any", 32'(any_pending), 0);
      check("rst_idx", 32'(out_idx), 0);
      check("rst_ovf", 32'(ovf), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_quiet_valid", 32'(out_valid), 0);
      end

      // Single request pulse on source 2, consumer always ready.
      out_ready = 1'b1;
      req       = 4'b0100;
      exp_q.push_back(2);
      tick();
      req = 4'b0000;
      check("single_any", 32'(any_pending), 1);
      check("single_valid_early", 32'(out_valid), 0);
      tick();
      check("single_valid", 32'(out_valid), 1);
      check("single_idx", 32'(out_idx), 2);
      tick();
      check("single_bubble", 32'(out_valid), 0);
      check("single_any_clr", 32'(any_pending), 0);
      tick();

      // Backpressure on source 1.
      out_ready = 1'b0;
      req       = 4'b0010;
      exp_q.push_back(1);
      tick();
      req = 4'b0000;
      tick();
      for (int i = 0; i < 6; i++) begin
         check("bp_valid", 32'(out_valid), 1);
         check("bp_idx", 32'(out_idx), 1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_done_valid", 32'(out_valid), 0);
      check("bp_done_any", 32'(any_pending), 0);
      tick(3);
      check("bp_one_xfer", 32'(xfer_count), 2);

      // Several sources at once; the last grant was source 1.
      req = 4'b1011;
`ifdef ROUND_ROBIN_EN
      exp_q.push_back(3);
      exp_q.push_back(0);
      exp_q.push_back(1);
`else
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(3);
`endif
      tick();
      req = 4'b0000;
      check("multi_any", 32'(any_pending), 1);
      tick(8);
      check("multi_drained", 32'(any_pending), 0);
      check("multi_sb_empty", 32'(exp_q.size()), 0);

      // Re-edge source 0 in the very cycle its index is consumed.
      out_ready = 1'b0;
      req       = 4'b0001;
      exp_q.push_back(0);
      tick();
      req = 4'b0000;
      tick();
      check("coll_offer", 32'(out_valid), 1);
      check("coll_offer_idx", 32'(out_idx), 0);
      req       = 4'b0001;
      out_ready = 1'b1;
      exp_q.push_back(0);
      tick();
      req = 4'b0000;
      check("coll_any", 32'(any_pending), 1);
      check("coll_bubble", 32'(out_valid), 0);
      check("coll_ovf", 32'(ovf), 0);
      tick();
      check("coll_reoffer", 32'(out_valid), 1);
      check("coll_reoffer_idx", 32'(out_idx), 0);
      tick();
      check("coll_any_clr", 32'(any_pending), 0);
      check("coll_ovf_after", 32'(ovf), 0);
      tick();

      // Two edges on source 3 before it is consumed.
      out_ready = 1'b0;
      req       = 4'b1000;
      exp_q.push_back(3);
      tick();
      req = 4'b0000;
      check("ovf_first_edge", 32'(ovf), 0);
      tick();
      req = 4'b1000;
      tick();
      req = 4'b0000;
      check("ovf_set", 32'(ovf), 1);
      check("ovf_hold_idx", 32'(out_idx), 3);
      out_ready = 1'b1;
      tick();
      check("ovf_drain_valid", 32'(out_valid), 0);
      check("ovf_drain_any", 32'(any_pending), 0);
      tick(3);
      check("ovf_sticky", 32'(ovf), 1);

      // Reset during an offer drops it with no transfer and clears ovf.
      out_ready = 1'b0;
      req       = 4'b0100;
      tick();
      req = 4'b0000;
      tick();
      check("mid_offer_valid", 32'(out_valid), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_any", 32'(any_pending), 0);
      check("mid_rst_ovf", 32'(ovf), 0);
      check("mid_rst_idx", 32'(out_idx), 0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_quiet", 32'(out_valid), 0);
      end

      check("sb_empty", 32'(exp_q.size()), 0);
      check("xfer_total", 32'(xfer_count), 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_req_source_decoder

// File: doc/req_source_decoder.md
# req_source_decoder

Receiving end of the team's wired-OR request line: N sources each drive one request bit, and the OR of them tells a consumer only that *something* is pending. This block recovers *which* source asked. It captures rising edges per source into a pending register, exposes the aggregate OR, and hands source indices one at a time to a consumer over a valid/ready handshake, clearing each bit as it is consumed. It sits between the OR-gate request fabric and the service/controller logic.

## Interface
- N, default 4: number of request sources (2..32).
- IDXW, default $clog2(N): index width. Derived; never overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-source request levels. Synchronous to clk.
- any_pending  output  1  OR of the pending register. No extra register stage.
- out_valid  output  1  an index is offered.
- out_idx  output  IDXW  offered source index. Stable while out_valid=1 and out_ready=0.
- out_ready  input  1  consumer accepts the offered index.
- ovf  output  1  sticky flag: a new edge arrived on a source whose bit was already pending. Cleared only by rst.

## Operation
- **Edge capture**
  - req_q is a registered copy of req.
  - edge = req & ~req_q.
  - Each clock: pending <= (pending & ~clr) | edge.
  - clr is a one-hot mask of out_idx, asserted in the cycle where out_valid & out_ready.
- **Simultaneous set and clear** on the same bit: the set wins, so the bit stays pending.
- **Overflow:** edge[i] & pending[i] & ~clr[i] sets ovf.
- **FSM states:** IDLE, OFFER.
  - IDLE: out_valid=0. If pending≠0, latch the picked index into out_idx and go to OFFER.
  - OFFER: out_valid=1, out_idx held.
    - out_ready=1: clear the bit and return to IDLE. This produces one bubble cycle.
    - out_ready=0: remain in OFFER.
- **Pick rule:** selected by the configuration macro (see Configuration).
- **Reset:** pending=0, req_q=0, state=IDLE, out_valid=0, out_idx=0, ovf=0, rr_ptr=0, any_pending=0.
  - Reset mid-OFFER drops the offer the next cycle with no transfer.
  - A req held high through reset does not produce an edge on the first post-reset cycle if req_q was already 1. Because req_q resets to 0, a req still high after reset is seen as a new edge.

## Timing
- req[i] rises before edge k:
  - pending[i] and any_pending are 1 after edge k.
  - out_valid=1 after edge k+1.
  - Request-to-valid latency is 2 cycles.
- Transfer happens at the edge where out_valid & out_ready. out_valid=0 for the following cycle (IDLE).
- Peak throughput: one index per 2 cycles.
- out_ready while out_valid=0 is ignored.
- out_idx never changes while out_valid=1.

## Configuration
- ROUND_ROBIN_EN defined:
  - rr_ptr <= (out_idx+1) mod N on each transfer.
  - The pick is the first pending bit searching upward from rr_ptr, wrapping at N-1→0.
- ROUND_ROBIN_EN undefined:
  - Fixed priority: the lowest pending index wins.
  - rr_ptr is absent.

## Structure
- **Package req_dec_pkg:**
  - state typedef (IDLE, OFFER).
  - Default N constant.
- **Sub-module req_pick:**
  - Purely combinational.
  - Inputs: pending and start pointer. Outputs: found flag and index.
  - Performs a masked find-first with wrap.
  - Fixed priority ties the start pointer to 0.

## Test plan
- **Reset:** hold rst with req=4'b1111, release with req=0 → all outputs 0; no valid in the next 5 cycles.
- **Single request:** pulse req=4'b0100 for 1 cycle, out_ready=1 →
  - any_pending=1 one cycle later.
  - out_valid=1 with out_idx=2 two cycles later.
  - Cleared after 1 transfer; any_pending=0.
- **Backpressure:** req=4'b0010 edge, out_ready=0 for 6 cycles → out_valid=1 and out_idx=1 held steady. Assert ready → exactly one transfer, then out_valid=0.
- **Multiple pending:** req=4'b1011 edge together, out_ready=1 →
  - Fixed priority: indices 0, 1, 3.
  - With ROUND_ROBIN_EN, after a prior grant of 1: order 3, 0, 1.
- **Set/clear collision:** re-edge source 0 in the same cycle its index transfers → pending[0] stays 1, 0 is offered again, ovf stays 0.
- **Overflow:** two edges on source 3 with out_ready=0 → ovf=1. It persists after the drain and clears only on rst.
